core_run_ctrl: RTL



---
 rtl/core_run_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/core_run_ctrl.sv
// Run/halt/single-step sequencer: debounced buttons, clock-enable divider, pulse counter.
// Optional breakpoint halt enabled by defining CORE_RUN_CTRL_BREAKPOINT_EN.

module core_run_deb #(
  parameter int DEB_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic          sync1, sync2, lvl, done;
  logic [DW-1:0] cnt;

  // done marks the edge that completes DEB_CYCLES mismatched cycles
  assign done  = (sync2 != lvl) && (cnt == DW'(DEB_CYCLES - 1));
  assign press = done && sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl   <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 == lvl || done) cnt <= '0;
      else                      cnt <= cnt + 1'b1;
      if (done) lvl <= sync2;
    end
  end
endmodule

module core_run_ctrl #(
  parameter int DIV_MAX    = 10000,
  parameter int DEB_CYCLES = 20000,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_step,
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_addr,
  input  logic             bp_valid,
`endif
  output logic             core_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt
);
  localparam int VW = $clog2(DIV_MAX);

  typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01, STEP = 2'b10} st_t;

  st_t           st_q, st_d;
  logic          en_d, tick;
  logic [1:0]    press;
  logic [VW-1:0] div;

  // bit 0: run/halt button, bit 1: step button
  core_run_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb [1:0] (
    .clk  (clk),
    .rst  (rst),
    .btn  ({btn_step, btn_run}),
    .press(press)
  );

  assign tick  = (div == VW'(DIV_MAX - 1));
  assign state = st_q;

`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
  logic first_q, first_d, bp_hit;
  // first tick after entering RUN skips the compare so a resume executes the breakpoint
  assign bp_hit = bp_valid && (pc == bp_addr) && !first_q;
`endif

  always_comb begin
    st_d = st_q;
    en_d = 1'b0;
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
    first_d = first_q;
`endif
    case (st_q)
      HALT: begin
        if (press[0]) begin
          st_d = RUN;
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
          first_d = 1'b1;
`endif
        end else if (press[1]) begin
          st_d = STEP;
        end
      end
      RUN: begin
        if (press[0]) begin
          st_d = HALT;
        end else if (tick) begin
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
          first_d = 1'b0;
          if (bp_hit) st_d = HALT;
          else        en_d = 1'b1;
`else
          en_d = 1'b1;
`endif
        end
      end
      STEP: begin
        if (tick) begin
          en_d = 1'b1;
          st_d = HALT;
        end
      end
      default: st_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= HALT;
      core_en   <= 1'b0;
      div       <= '0;
      cycle_cnt <= '0;
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
      first_q   <= 1'b0;
`endif
    end else begin
      st_q      <= st_d;
      core_en   <= en_d;
      div       <= tick ? '0 : div + 1'b1;
      cycle_cnt <= cycle_cnt + CNT_W'(core_en);
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
      first_q   <= first_d;
`endif
    end
  end
endmodule
